// File: rtl/uart_cfg.sv
// uart_cfg: runtime-configurable full-duplex UART (5-8 data bits, none/even/odd
// parity, 1 or 2 stop bits), 16x oversampling from one shared baud tick, with a
// FIFO on each direction.
// Optional feature macro: UART_LOOPBACK_EN adds a 'loopback' input that feeds
// the receiver from tx internally. When it is undefined, RX always uses rx.
//
// Host interface: wr_uart and rd_uart are single-cycle strobes. tx_full acts as
// the not-ready of the TX queue and rx_empty as the not-valid of the RX queue.
// A write strobe while tx_full is 1 is dropped, unless a pop happens in the same
// cycle. A read strobe while rx_empty is 1 is dropped. r_data always shows the
// RX head, without waiting for the read.

// Synchronous FIFO with first-word fall-through output and registered flags.
module uart_fifo #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              full_o,
  output logic              empty_o
);
  localparam logic [ADDR_W-1:0] PTR_ONE = 1;

  logic [DATA_W-1:0] mem_q [0:2**ADDR_W-1];
  logic [ADDR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic              full_q, full_d, empty_q, empty_d;
  logic              push_ok, pop_ok;

  // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
  assign pop_ok  = pop_i & ~empty_q;
  assign push_ok = push_i & (~full_q | pop_ok);

  // Next pointers and flags.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    full_d  = full_q;
    empty_d = empty_q;
    if (push_ok) wptr_d = wptr_q + PTR_ONE;
    if (pop_ok)  rptr_d = rptr_q + PTR_ONE;
    if (push_ok && !pop_ok) begin
      empty_d = 1'b0;
      full_d  = (wptr_d == rptr_q);
    end else if (pop_ok && !push_ok) begin
      full_d  = 1'b0;
      empty_d = (rptr_d == wptr_q);
    end
  end

  // Pointer and flag registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  // Storage array. It needs no reset because it is only read when the FIFO is not empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = empty_q ? '0 : mem_q[rptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
endmodule

module uart_cfg #(
  parameter int FIFO_ADDR_W = 4,
  parameter int TIMER_W     = 11
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [TIMER_W-1:0] TIMER_FINAL_VALUE,
  input  logic [1:0]         data_bits,
  input  logic [1:0]         parity_mode,
  input  logic               stop_bits,
  input  logic               rx,
  output logic               tx,
`ifdef UART_LOOPBACK_EN
  input  logic               loopback,
`endif
  input  logic               wr_uart,
  input  logic [7:0]         w_data,
  output logic               tx_full,
  output logic               tx_empty,
  input  logic               rd_uart,
  output logic [7:0]         r_data,
  output logic               rx_empty,
  output logic               data_valid,
  output logic               parity_err,
  output logic               frame_err,
  output logic               rx_overrun,
  output logic [2:0]         dbg_rx_state_o,
  output logic [2:0]         dbg_tx_state_o
);
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  localparam logic [TIMER_W-1:0] TIMER_ONE = 1;

  // Mask that keeps only the data bits of a word (5..8 bits).
  function automatic logic [7:0] data_mask(input logic [1:0] db);
    return 8'hFF >> (2'd3 - db);
  endfunction

  // ---------------- Baud tick ----------------
  logic [TIMER_W-1:0] baud_q, baud_d;
  logic               tick;

  // The compare is >=, so lowering the divisor during a count wraps at once.
  assign tick   = (baud_q >= TIMER_FINAL_VALUE);
  assign baud_d = tick ? '0 : baud_q + TIMER_ONE;

  // Free-running divisor counter.
  always_ff @(posedge clk) begin
    if (!reset_n) baud_q <= '0;
    else          baud_q <= baud_d;
  end

  // ---------------- TX path ----------------
  logic       tx_pop, tx_out;
  logic [7:0] tx_head, tx_masked;
  state_e     tx_state_q, tx_state_d;
  logic [3:0] tx_tick_q, tx_tick_d;
  logic [2:0] tx_bit_q, tx_bit_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [1:0] tx_db_q, tx_db_d;
  logic       tx_par_q, tx_par_d, tx_pen_q, tx_pen_d;
  logic       tx_stop2_q, tx_stop2_d, tx_sidx_q, tx_sidx_d;
  logic       tx_bit_done;

  uart_fifo #(.ADDR_W(FIFO_ADDR_W), .DATA_W(8)) u_tx_fifo (
    .clk(clk), .reset_n(reset_n), .push_i(wr_uart), .pop_i(tx_pop),
    .wdata_i(w_data), .rdata_o(tx_head), .full_o(tx_full), .empty_o(tx_empty)
  );

  assign tx_masked   = tx_head & data_mask(data_bits);
  assign tx_bit_done = tick && (tx_tick_q == 4'd15);

  // TX next state. A frame starts on a tick, so every bit spans exactly 16 ticks.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_tick_d  = tx_tick_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_db_d    = tx_db_q;
    tx_par_d   = tx_par_q;
    tx_pen_d   = tx_pen_q;
    tx_stop2_d = tx_stop2_q;
    tx_sidx_d  = tx_sidx_q;
    tx_pop     = 1'b0;
    tx_out     = 1'b1;
    if (tick) tx_tick_d = tx_tick_q + 4'd1;
    case (tx_state_q)
      S_IDLE: begin
        tx_tick_d = '0;
        if (tick && !tx_empty) begin
          tx_pop     = 1'b1;
          tx_state_d = S_START;
          tx_shift_d = tx_masked;
          tx_par_d   = (^tx_masked) ^ (parity_mode == 2'b10);
          tx_pen_d   = parity_mode[0] ^ parity_mode[1];
          tx_db_d    = data_bits;
          tx_stop2_d = stop_bits;
          tx_sidx_d  = 1'b0;
          tx_bit_d   = '0;
        end
      end
      S_START: begin
        tx_out = 1'b0;
        if (tx_bit_done) tx_state_d = S_DATA;
      end
      S_DATA: begin
        tx_out = tx_shift_q[0];
        if (tx_bit_done) begin
          tx_shift_d = tx_shift_q >> 1;
          tx_bit_d   = tx_bit_q + 3'd1;
          if (tx_bit_q == {1'b1, tx_db_q}) tx_state_d = tx_pen_q ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        tx_out = tx_par_q;
        if (tx_bit_done) tx_state_d = S_STOP;
      end
      S_STOP: begin
        tx_out = 1'b1;
        if (tx_bit_done) begin
          if (tx_stop2_q && !tx_sidx_q) tx_sidx_d = 1'b1;
          else                          tx_state_d = S_IDLE;
        end
      end
      default: tx_state_d = S_IDLE;
    endcase
  end

  // TX state registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tx_state_q <= S_IDLE;
      tx_tick_q  <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_db_q    <= '0;
      tx_par_q   <= 1'b0;
      tx_pen_q   <= 1'b0;
      tx_stop2_q <= 1'b0;
      tx_sidx_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_tick_q  <= tx_tick_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_db_q    <= tx_db_d;
      tx_par_q   <= tx_par_d;
      tx_pen_q   <= tx_pen_d;
      tx_stop2_q <= tx_stop2_d;
      tx_sidx_q  <= tx_sidx_d;
    end
  end

  assign tx = tx_out;

  // ---------------- RX path ----------------
  logic       rx_src, rx_s, rx_mid, rx_full;
  logic [1:0] rx_sync_q;
  state_e     rx_state_q, rx_state_d;
  logic [3:0] rx_tick_q, rx_tick_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic [7:0] rx_shift_q, rx_shift_d, rx_word;
  logic [1:0] rx_db_q, rx_db_d;
  logic       rx_pen_q, rx_pen_d, rx_odd_q, rx_odd_d;
  logic       rx_stop2_q, rx_stop2_d, rx_sidx_q, rx_sidx_d;
  logic       rx_perr_q, rx_perr_d, rx_ferr_q, rx_ferr_d, rx_push_q, rx_push_d;

`ifdef UART_LOOPBACK_EN
  assign rx_src = loopback ? tx_out : rx;
`else
  assign rx_src = rx;
`endif

  // Two-flop synchroniser on the serial input. It resets to the idle level.
  always_ff @(posedge clk) begin
    if (!reset_n) rx_sync_q <= 2'b11;
    else          rx_sync_q <= {rx_sync_q[0], rx_src};
  end

  assign rx_s   = rx_sync_q[1];
  assign rx_mid = tick && (rx_tick_q == 4'd15);

  // RX next state. START re-centres the count at mid start bit, so each later sample lands mid-bit.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_tick_d  = rx_tick_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_db_d    = rx_db_q;
    rx_pen_d   = rx_pen_q;
    rx_odd_d   = rx_odd_q;
    rx_stop2_d = rx_stop2_q;
    rx_sidx_d  = rx_sidx_q;
    rx_perr_d  = rx_perr_q;
    rx_ferr_d  = rx_ferr_q;
    rx_push_d  = 1'b0;
    if (tick) rx_tick_d = rx_tick_q + 4'd1;
    case (rx_state_q)
      S_IDLE: begin
        rx_tick_d = '0;
        if (!rx_s) begin
          rx_state_d = S_START;
          rx_db_d    = data_bits;
          rx_pen_d   = parity_mode[0] ^ parity_mode[1];
          rx_odd_d   = (parity_mode == 2'b10);
          rx_stop2_d = stop_bits;
          rx_sidx_d  = 1'b0;
          rx_bit_d   = '0;
          rx_shift_d = '0;
          rx_perr_d  = 1'b0;
          rx_ferr_d  = 1'b0;
        end
      end
      S_START: begin
        if (tick && rx_tick_q == 4'd7) begin
          rx_tick_d  = '0;
          rx_state_d = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (rx_mid) begin
          rx_shift_d = {rx_s, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == {1'b1, rx_db_q}) rx_state_d = rx_pen_q ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (rx_mid) begin
          rx_perr_d  = (^rx_shift_q) ^ rx_s ^ rx_odd_q;
          rx_state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (rx_mid) begin
          if (!rx_s) rx_ferr_d = 1'b1;
          if (rx_stop2_q && !rx_sidx_q) begin
            rx_sidx_d = 1'b1;
          end else begin
            rx_state_d = S_IDLE;
            rx_push_d  = 1'b1;
          end
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  // RX state registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_state_q <= S_IDLE;
      rx_tick_q  <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_db_q    <= '0;
      rx_pen_q   <= 1'b0;
      rx_odd_q   <= 1'b0;
      rx_stop2_q <= 1'b0;
      rx_sidx_q  <= 1'b0;
      rx_perr_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
      rx_push_q  <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_tick_q  <= rx_tick_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_db_q    <= rx_db_d;
      rx_pen_q   <= rx_pen_d;
      rx_odd_q   <= rx_odd_d;
      rx_stop2_q <= rx_stop2_d;
      rx_sidx_q  <= rx_sidx_d;
      rx_perr_q  <= rx_perr_d;
      rx_ferr_q  <= rx_ferr_d;
      rx_push_q  <= rx_push_d;
    end
  end

  // Bits were shifted in at the MSB, so right-align them. This leaves the unused MSBs at zero.
  assign rx_word = rx_shift_q >> (2'd3 - rx_db_q);

  uart_fifo #(.ADDR_W(FIFO_ADDR_W), .DATA_W(8)) u_rx_fifo (
    .clk(clk), .reset_n(reset_n), .push_i(rx_push_q), .pop_i(rd_uart),
    .wdata_i(rx_word), .rdata_o(r_data), .full_o(rx_full), .empty_o(rx_empty)
  );

  // A push is accepted when the FIFO has room or a read frees a slot in the same cycle.
  assign data_valid = rx_push_q & (~rx_full | rd_uart);
  assign rx_overrun = rx_push_q & ~data_valid;
  assign parity_err = data_valid & rx_perr_q;
  assign frame_err  = data_valid & rx_ferr_q;

  assign dbg_rx_state_o = rx_state_q;
  assign dbg_tx_state_o = tx_state_q;
endmodule
